// File: rtl/mux_ser_pkg.sv
// Shared types and helpers for the mux-driving serial sequencer.
// Includes the FSM state enum, default sizes, and select start/terminal indices.
package mux_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned SEL_W_DEF = 4;

    typedef struct packed {
        logic [31:0] start_idx;
        logic [31:0] term_idx;
    } sel_range_t;

    function automatic sel_range_t sel_range(input int unsigned width, input bit msb_first);
        sel_range_t r;
        if (msb_first) begin
            r.start_idx = width - 1;
            r.term_idx  = '0;
        end else begin
            r.start_idx = '0;
            r.term_idx  = width - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_ser_sequencer_sel_step_counter.sv
// Loadable up/down select counter with enable and terminal flag.
// It parks at the terminal value, so the select never wraps.
module sel_step_counter
    import mux_ser_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [SEL_W-1:0] term_val,
    output logic [SEL_W-1:0] cnt,
    output logic             at_term
);

    assign at_term = (cnt == term_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !at_term) begin
            cnt <= down ? (cnt - 1'b1) : (cnt + 1'b1);
        end
    end

endmodule

// File: rtl/mux_ser_sequencer.sv
// Parallel-to-serial sequencer driving an external 16:1 bit-select mux.
// Optional even-parity trailer beat when MUX_SER_PARITY_EN is defined.
module mux_ser_sequencer
    import mux_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last
);

    localparam sel_range_t       RANGE = sel_range(WIDTH, MSB_FIRST);
    localparam logic [SEL_W-1:0] START = RANGE.start_idx[SEL_W-1:0];
    localparam logic [SEL_W-1:0] TERM  = RANGE.term_idx[SEL_W-1:0];

    state_t state, state_nx;
    logic   load;
    logic   step;
    logic   at_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mux_in <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                mux_in <= word_in;
            end
        end
    end

    sel_step_counter #(
        .SEL_W (SEL_W)
    ) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (START),
        .en       (step),
        .down     (MSB_FIRST),
        .term_val (TERM),
        .cnt      (mux_sel),
        .at_term  (at_term)
    );

    // Outputs decode from state only, so ser_valid cannot drop before a handshake.
    always_comb begin
        state_nx   = state;
        word_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        ser_last   = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = mux_out;
`ifdef MUX_SER_PARITY_EN
                ser_last  = 1'b0;
`else
                ser_last  = at_term;
`endif
                if (ser_ready) begin
                    if (at_term) begin
`ifdef MUX_SER_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = IDLE;
`endif
                    end else begin
                        step = 1'b1;
                    end
                end
            end
`ifdef MUX_SER_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_bit   = ^mux_in;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_nx = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_ser_sequencer.sv
// Self-checking bench for mux_ser_sequencer; LSB-first and MSB-first instances run in lockstep.
// Honours MUX_SER_PARITY_EN for the expected frame length and parity beat.
module tb_mux_ser_sequencer;

    localparam int W = 16;
`ifdef MUX_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        ser_ready = 1'b0;

    logic        wr_l, wr_m, mo_l, mo_m, sb_l, sb_m, sv_l, sv_m, sl_l, sl_m;
    logic [15:0] mi_l, mi_m;
    logic [3:0]  ms_l, ms_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External 16:1 mux models
    assign mo_l = mi_l[ms_l];
    assign mo_m = mi_m[ms_m];

    mux_ser_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(wr_l), .mux_in(mi_l), .mux_sel(ms_l), .mux_out(mo_l),
        .ser_bit(sb_l), .ser_valid(sv_l), .ser_ready(ser_ready), .ser_last(sl_l)
    );

    mux_ser_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(wr_m), .mux_in(mi_m), .mux_sel(ms_m), .mux_out(mo_m),
        .ser_bit(sb_m), .ser_valid(sv_m), .ser_ready(ser_ready), .ser_last(sl_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_l"}, 32'(wr_l), 32'd1);
        check({tag, "_wr_m"}, 32'(wr_m), 32'd1);
        check({tag, "_sv_l"}, 32'(sv_l), 32'd0);
        check({tag, "_sv_m"}, 32'(sv_m), 32'd0);
        check({tag, "_sl_l"}, 32'(sl_l), 32'd0);
        check({tag, "_sl_m"}, 32'(sl_m), 32'd0);
        check({tag, "_sel_l"}, 32'(ms_l), 32'd0);
        check({tag, "_sel_m"}, 32'(ms_m), 32'd0);
        check({tag, "_in_l"}, 32'(mi_l), 32'd0);
        check({tag, "_in_m"}, 32'(mi_m), 32'd0);
    endtask

    task automatic check_idle(input logic [15:0] prev);
        check("idle_wr_l", 32'(wr_l), 32'd1);
        check("idle_wr_m", 32'(wr_m), 32'd1);
        check("idle_sv_l", 32'(sv_l), 32'd0);
        check("idle_sv_m", 32'(sv_m), 32'd0);
        check("idle_sl_l", 32'(sl_l), 32'd0);
        check("idle_in_l", 32'(mi_l), 32'(prev));
        check("idle_in_m", 32'(mi_m), 32'(prev));
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic send_word(input logic [15:0] w, input int mode, input int abort_beat,
                             input bit hold_next, input logic [15:0] next_w,
                             input logic [15:0] prev);
        int       k;
        int       cyc;
        int       stalls;
        logic     r;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        cyc = 0;
        stalls = 0;
        check_idle(prev);
        word_in = w;
        word_valid = 1'b1;
        ser_ready = 1'b0;
        @(posedge clk); #1;
        if (hold_next) word_in = next_w;
        else word_valid = 1'b0;
        while (k < W + PAR) begin
            if (k == abort_beat) begin
                ser_ready = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            case (mode)
                0: r = 1'b1;
                1: r = pat[cyc % 4];
                default: r = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            ser_ready = r;
            #1;
            check("beat_sv_l", 32'(sv_l), 32'd1);
            check("beat_sv_m", 32'(sv_m), 32'd1);
            check("beat_wr_l", 32'(wr_l), 32'd0);
            check("beat_wr_m", 32'(wr_m), 32'd0);
            check("beat_in_l", 32'(mi_l), 32'(w));
            check("beat_in_m", 32'(mi_m), 32'(w));
            if (k < W) begin
                check("beat_sel_l", 32'(ms_l), 32'(k));
                check("beat_sel_m", 32'(ms_m), 32'(W - 1 - k));
                check("beat_bit_l", 32'(sb_l), 32'(w[k]));
                check("beat_bit_m", 32'(sb_m), 32'(w[W - 1 - k]));
                check("beat_last_l", 32'(sl_l), 32'((PAR == 0) && (k == W - 1)));
                check("beat_last_m", 32'(sl_m), 32'((PAR == 0) && (k == W - 1)));
            end else begin
                check("par_sel_l", 32'(ms_l), 32'(W - 1));
                check("par_sel_m", 32'(ms_m), 32'd0);
                check("par_bit_l", 32'(sb_l), 32'(^w));
                check("par_bit_m", 32'(sb_m), 32'(^w));
                check("par_last_l", 32'(sl_l), 32'd1);
                check("par_last_m", 32'(sl_m), 32'd1);
            end
            @(posedge clk); #1;
            if (r) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
            cyc++;
        end
        ser_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] rw;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_word(16'hA5C3, 0, -1, 1'b0, 16'h0000, 16'h0000);
        send_word(16'h0001, 1, -1, 1'b0, 16'h0000, 16'hA5C3);
        send_word(16'hFFFF, 0, -1, 1'b1, 16'h0000, 16'h0001);
        send_word(16'h0000, 2, -1, 1'b0, 16'h0000, 16'hFFFF);
        send_word(16'h1234, 0, 7, 1'b0, 16'h0000, 16'h0000);
        send_word(16'h8000, 0, -1, 1'b0, 16'h0000, 16'h0000);
        send_word(16'h0007, 0, -1, 1'b0, 16'h0000, 16'h8000);
        send_word(16'h0003, 1, -1, 1'b0, 16'h0000, 16'h0007);
        prev = 16'h0003;
        for (int i = 0; i < 6; i++) begin
            rw = 16'($urandom);
            send_word(rw, 2, -1, 1'b0, 16'h0000, prev);
            prev = rw;
        end
        check_idle(prev);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
